// File: rtl/gpa_fhdo_spi_master.sv
// -----------------------------------------------------------------------------
// gpa_fhdo_spi_master
// SPI master that forwards 24-bit command words from the gradient sequencer to
// the GPA-FHDO board's DAC80504. Each accepted request produces one
// chip-select-framed, MSB-first transfer. SCLK idles high, the DAC samples on
// SCLK falling edges, and SCLK's half-period is (spi_clk_div_i + 1) clk cycles.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   data_i[31:0]   command word; [FRAME_BITS-1:0] is the frame, upper bits ignored
//   valid_i        request strobe, accepted on its rising edge while idle
//   spi_clk_div_i  SCLK divider D (half-period = D+1 clk cycles)
//   busy_o         high from acceptance until the post-frame gap has elapsed
//   fhd_clk_o      SPI SCLK (idles high)
//   fhd_sdo_o      SPI MOSI
//   fhd_csn_o      SPI chip select, active low
//   fhd_sdi_i      SPI MISO, captured into an internal shadow register only
// -----------------------------------------------------------------------------
module gpa_fhdo_spi_master #(
   parameter int FRAME_BITS = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_i,
   input  logic        valid_i,
   input  logic [5:0]  spi_clk_div_i,
   output logic        busy_o,
   output logic        fhd_clk_o,
   output logic        fhd_sdo_o,
   output logic        fhd_csn_o,
   input  logic        fhd_sdi_i
);

   // One SCLK toggle per half-period: two toggles per frame bit.
   localparam int             EW        = $clog2(2 * FRAME_BITS);
   localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * FRAME_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CS_HOLD,
      ST_GAP
   } state_t;

   state_t                  r_state;
   logic                    r_valid_q;
   logic                    r_busy;
   logic                    r_sclk;
   logic                    r_sdo;
   logic                    r_csn;
   logic [5:0]              r_div;
   logic [5:0]              r_cnt;
   logic [EW-1:0]           r_edges;
   logic [FRAME_BITS-1:0]   r_shift;
   logic [FRAME_BITS-1:0]   r_miso;

   logic w_start;
   logic w_tick;
   logic w_unused;

   assign w_start = valid_i && !r_valid_q && (r_state == ST_IDLE);
   assign w_tick  = (r_cnt == r_div);

   assign busy_o    = r_busy;
   assign fhd_clk_o = r_sclk;
   assign fhd_sdo_o = r_sdo;
   assign fhd_csn_o = r_csn;

   // MISO shadow and the reserved command bits have no consumer; the top shift
   // bit is never read because the first bit is driven straight from data_i.
   assign w_unused = &{1'b0, data_i[31:FRAME_BITS], r_miso, r_shift[FRAME_BITS-1]};

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_valid_q <= 1'b0;
         r_busy    <= 1'b0;
         r_sclk    <= 1'b1;
         r_sdo     <= 1'b0;
         r_csn     <= 1'b1;
         r_div     <= '0;
         r_cnt     <= '0;
         r_edges   <= '0;
         r_shift   <= '0;
         r_miso    <= '0;
      end else begin
         r_valid_q <= valid_i;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_shift <= data_i[FRAME_BITS-1:0];
                  r_sdo   <= data_i[FRAME_BITS-1];
                  r_div   <= spi_clk_div_i;
                  r_cnt   <= '0;
                  r_edges <= '0;
                  r_busy  <= 1'b1;
                  r_csn   <= 1'b0;
                  r_sclk  <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               if (w_tick) begin
                  r_cnt   <= '0;
                  r_sclk  <= ~r_sclk;
                  r_edges <= r_edges + 1'b1;
                  // SCLK currently low: this toggle is a rising edge.
                  if (!r_sclk) begin
                     r_miso <= {r_miso[FRAME_BITS-2:0], fhd_sdi_i};
                     if (r_edges == LAST_EDGE) begin
                        r_csn   <= 1'b1;
                        r_sdo   <= 1'b0;
                        r_state <= ST_CS_HOLD;
                     end else begin
                        r_shift <= r_shift << 1;
                        r_sdo   <= r_shift[FRAME_BITS-2];
                     end
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // CS_HOLD is the first cycle after CSN rises; GAP continues the
            // same H-cycle count, so with D=0 the wait ends in CS_HOLD itself.
            ST_CS_HOLD, ST_GAP: begin
               if (w_tick) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= ST_GAP;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpa_fhdo_spi_master.sv
// -----------------------------------------------------------------------------
// Self-checking bench for gpa_fhdo_spi_master. A bus observer samples the SPI
// pins on every clk falling edge, reassembles the frame from SDO at SCLK
// falling edges and measures busy/CSN durations; expected values come from the
// frame/timing rules (frame = data[23:0], busy = 49*H, CSN low = 48*H).
// A small DAC80504 register model decodes write frames to channel values.
// -----------------------------------------------------------------------------
module tb_gpa_fhdo_spi_master;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_i;
   logic        valid_i;
   logic [5:0]  spi_clk_div_i;
   logic        busy_o;
   logic        fhd_clk_o;
   logic        fhd_sdo_o;
   logic        fhd_csn_o;
   logic        fhd_sdi_i;

   int vectors;
   int miscompares;

   // Observer results of the last run_frame call.
   int          busy_cycles;
   int          csn_cycles;
   int          nfalls;
   int          first_fall;
   int          second_fall;
   int          retrig;
   logic [23:0] bits;

   logic [15:0] dac_ch [4];

   gpa_fhdo_spi_master #(.FRAME_BITS(24)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_i        (data_i),
      .valid_i       (valid_i),
      .spi_clk_div_i (spi_clk_div_i),
      .busy_o        (busy_o),
      .fhd_clk_o     (fhd_clk_o),
      .fhd_sdo_o     (fhd_sdo_o),
      .fhd_csn_o     (fhd_csn_o),
      .fhd_sdi_i     (fhd_sdi_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // DAC80504 write frame: bit23=0 (write), address 0x08..0x0B = DAC0..DAC3.
   task automatic dac_apply(input logic [23:0] frame);
      logic [7:0] cmd;
      cmd = frame[23:16];
      if (!cmd[7] && cmd[6:0] >= 7'h08 && cmd[6:0] <= 7'h0B)
         dac_ch[cmd[1:0]] = frame[15:0];
   endtask

   // Issue one request and observe until busy_o drops (bounded).
   //   hold_cycles: >0 keeps valid_i high for that many cycles in total
   //   inject_at  : sample index at which a second one-cycle valid pulse is sent
   //   abort_at   : sample index at which rst_n is asserted mid-transfer
   task automatic run_frame(input logic [31:0] data, input logic [5:0] d,
                            input int hold_cycles, input int inject_at, input int abort_at);
      int   k;
      logic prev_sclk;
      bit   aborted;
      @(negedge clk);
      data_i        = data;
      spi_clk_div_i = d;
      valid_i       = 1'b1;
      busy_cycles = 0; csn_cycles = 0; nfalls = 0; first_fall = 0; second_fall = 0;
      retrig = 0; bits = '0; prev_sclk = 1'b1; aborted = 1'b0; k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            // Inputs scrambled after acceptance must not affect the frame.
            data_i        = $urandom;
            spi_clk_div_i = 6'($urandom);
            if (hold_cycles == 0) valid_i = 1'b0;
         end
         if (inject_at > 0 && k == inject_at)     valid_i = 1'b1;
         if (inject_at > 0 && k == inject_at + 1) valid_i = 1'b0;
         if (abort_at > 0 && k == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_busy", 32'(busy_o),    32'd0);
            check("abort_csn",  32'(fhd_csn_o), 32'd1);
            check("abort_sclk", 32'(fhd_clk_o), 32'd1);
            check("abort_sdo",  32'(fhd_sdo_o), 32'd0);
            aborted = 1'b1;
         end else begin
            if (busy_o)     busy_cycles++;
            if (!fhd_csn_o) csn_cycles++;
            if (prev_sclk && !fhd_clk_o && !fhd_csn_o) begin
               nfalls++;
               bits = {bits[22:0], fhd_sdo_o};
               if (nfalls == 1) first_fall  = k;
               if (nfalls == 2) second_fall = k;
            end
            prev_sclk = fhd_clk_o;
         end
      end while (busy_o && k < 4000 && !aborted);
      if (hold_cycles > 0) begin
         for (int j = k; j < hold_cycles; j++) begin
            @(negedge clk);
            if (busy_o) retrig++;
         end
         valid_i = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] rdata;
      logic [5:0]  rdiv;
      int          h;

      vectors = 0; miscompares = 0;
      rst_n = 1'b0; valid_i = 1'b0; data_i = '0; spi_clk_div_i = '0; fhd_sdi_i = 1'b0;
      for (int c = 0; c < 4; c++) dac_ch[c] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy_o),    32'd0);
      check("rst_csn",  32'(fhd_csn_o), 32'd1);
      check("rst_sclk", 32'(fhd_clk_o), 32'd1);
      check("rst_sdo",  32'(fhd_sdo_o), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single frame, D=32
      run_frame(32'h0000_00AB, 6'd32, 0, 0, 0);
      check("single_busy",   busy_cycles, 49 * 33);
      check("single_csn",    csn_cycles,  48 * 33);
      check("single_nfalls", nfalls,      24);
      check("single_bits",   32'(bits),   32'h0000AB);
      check("single_fall1",  first_fall,  33 + 1);
      check("single_period", second_fall - first_fall, 2 * 33);

      // Back-to-back writes to all four DAC channels
      for (int i = 0; i < 4; i++) begin
         run_frame({8'h00, 8'(8'h08 + i), 16'(16'h000A + i)}, 6'd32, 0, 0, 0);
         check("b2b_busy", busy_cycles, 49 * 33);
         if (nfalls == 24) dac_apply(bits);
      end
      for (int i = 0; i < 4; i++)
         check($sformatf("dac_ch%0d", i), 32'(dac_ch[i]), 32'(16'h000A + i));

      // valid_i held high for 2000 cycles -> one frame only
      run_frame(32'h0000_0006, 6'd32, 2000, 0, 0);
      check("held_bits",   32'(bits), 32'h000006);
      check("held_nfalls", nfalls,    24);
      check("held_retrig", retrig,    0);

      // Second edge while busy is dropped
      run_frame(32'h0012_3456, 6'd32, 0, 800, 0);
      check("drop_bits",   32'(bits), 32'h123456);
      check("drop_nfalls", nfalls,    24);
      repeat (5) @(negedge clk);
      check("drop_idle",   32'(busy_o), 32'd0);

      // D=0 and D=63 extremes, reserved bits set
      rdata = $urandom;
      run_frame(rdata, 6'd0, 0, 0, 0);
      check("d0_busy",   busy_cycles, 49);
      check("d0_period", second_fall - first_fall, 2);
      check("d0_bits",   32'(bits), 32'(rdata[23:0]));
      rdata = {8'hFF, 24'($urandom)};
      run_frame(rdata, 6'd63, 0, 0, 0);
      check("d63_busy", busy_cycles, 49 * 64);
      check("d63_bits", 32'(bits), 32'(rdata[23:0]));

      // Randomized frames with small dividers
      for (int i = 0; i < 6; i++) begin
         rdata = $urandom;
         rdiv  = 6'($urandom_range(0, 5));
         h     = int'(rdiv) + 1;
         run_frame(rdata, rdiv, 0, 0, 0);
         check("rand_bits",  32'(bits),   32'(rdata[23:0]));
         check("rand_busy",  busy_cycles, 49 * h);
         check("rand_fall1", first_fall,  h + 1);
      end

      // Reset mid-transfer, then quiet bus until a new request
      run_frame(32'h00AA_AAAA, 6'd32, 0, 0, 300);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      retrig = 0;
      for (int j = 0; j < 200; j++) begin
         @(negedge clk);
         if (!fhd_clk_o || !fhd_csn_o || busy_o) retrig++;
      end
      check("post_rst_quiet", retrig, 0);
      run_frame(32'h0055_1234, 6'd1, 0, 0, 0);
      check("post_rst_bits", 32'(bits),   32'h551234);
      check("post_rst_busy", busy_cycles, 49 * 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
